// File: rtl/scan_seq_pkg.sv
// -----------------------------------------------------------------------------
// scan_seq_pkg
// Shared definitions for the scan_sequencer frame controller.
//   state_e    : FSM state encoding (IDLE=0, ARM=1, START=2, SCAN=3, GAP=4)
//   ARM_CYCLES : number of cycles spent in ARM before START (speak settle time)
// -----------------------------------------------------------------------------
package scan_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_SCAN  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int unsigned ARM_CYCLES = 32'd2;

endpackage : scan_seq_pkg

// File: rtl/marker_sync.sv
// -----------------------------------------------------------------------------
// marker_sync
// Brings the asynchronous frame-end marker into the clk_s domain through a
// 2-flop synchroniser, then turns each rising edge into a 1-cycle event.
// A level held high yields exactly one event.
// Ports:
//   clk_s      in  : clock
//   rst_n_s    in  : asynchronous active-low reset
//   marker_a   in  : raw marker from the scanner (asynchronous)
//   marker_evt out : 1-cycle rising-edge event, clk_s domain
// -----------------------------------------------------------------------------
module marker_sync (
  input  logic clk_s,
  input  logic rst_n_s,
  input  logic marker_a,
  output logic marker_evt
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchroniser chain plus the previous-value register for edge detection.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= marker_a;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign marker_evt = sync2_q & ~prev_q;

endmodule : marker_sync

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// Frame-level controller in front of the pixel scanner. Runs a configured
// number of frames (0 = continuous) with a programmable idle gap between
// frames, counts completed frames and aborts a scan whose marker never comes.
// Ports:
//   clk_s, rst_n_s   : clock, asynchronous active-low reset
//   run_i, stop_i    : 1-cycle start / stop commands
//   cfg_frames_i     : frames to run (0 = continuous), latched at run
//   cfg_gap_i        : idle cycles between frames, latched at run
//   marker_a         : asynchronous frame-end marker from the scanner
//   start_s, speak_s : scanner start pulse and enable
//   busy_o           : state is not IDLE
//   done_o           : 1-cycle pulse on normal return to IDLE
//   timeout_err_o    : sticky watchdog error, cleared by the next run
//   frame_cnt_o      : completed frames, saturating
// All outputs are registered.
// -----------------------------------------------------------------------------
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned GAP_WIDTH       = 8,
  parameter int unsigned TIMEOUT         = 20000,
  parameter int unsigned TIMEOUT_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk_s,
  input  logic                       rst_n_s,
  input  logic                       run_i,
  input  logic                       stop_i,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_frames_i,
  input  logic [GAP_WIDTH-1:0]       cfg_gap_i,
  input  logic                       marker_a,
  output logic                       start_s,
  output logic                       speak_s,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_err_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

  state_e                     state_q;
  state_e                     state_d;
  logic [FRAME_CNT_WIDTH-1:0] frames_q;
  logic [GAP_WIDTH-1:0]       gap_q;
  logic [GAP_WIDTH-1:0]       cnt_q;     // shared ARM / GAP down-counter
  logic [TIMEOUT_WIDTH-1:0]   wd_q;
  logic                       stop_pend_q;

  logic                       marker_evt;
  logic                       accept_run_d;
  logic                       frame_evt_d;
  logic                       done_d;
  logic                       wd_fire_d;
  logic [FRAME_CNT_WIDTH-1:0] cnt_next_d;

  marker_sync u_marker_sync (
    .clk_s     (clk_s),
    .rst_n_s   (rst_n_s),
    .marker_a  (marker_a),
    .marker_evt(marker_evt)
  );

  // Next-state and transition-event decode.
  always_comb begin
    state_d      = state_q;
    accept_run_d = 1'b0;
    frame_evt_d  = 1'b0;
    done_d       = 1'b0;
    wd_fire_d    = 1'b0;
    if (frame_cnt_o == {FRAME_CNT_WIDTH{1'b1}}) begin
      cnt_next_d = frame_cnt_o;
    end else begin
      cnt_next_d = frame_cnt_o + FRAME_CNT_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // stop wins over a simultaneous run
        if (run_i && !stop_i) begin
          state_d      = ST_ARM;
          accept_run_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == GAP_WIDTH'(0)) begin
          state_d = ST_START;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_START: begin
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // a marker arriving on the last watchdog cycle still counts
        if (marker_evt) begin
          frame_evt_d = 1'b1;
          if (stop_i || stop_pend_q ||
              ((frames_q != FRAME_CNT_WIDTH'(0)) && (cnt_next_d == frames_q))) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_q == GAP_WIDTH'(0)) begin
            state_d = ST_START;
          end else begin
            state_d = ST_GAP;
          end
        end else if (wd_q == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          wd_fire_d = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_GAP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == GAP_WIDTH'(0)) begin
          state_d = ST_START;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters, configuration latches and registered outputs.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q       <= ST_IDLE;
      frames_q      <= '0;
      gap_q         <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      stop_pend_q   <= 1'b0;
      start_s       <= 1'b0;
      speak_s       <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_err_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      state_q <= state_d;
      start_s <= (state_d == ST_START);
      speak_s <= (state_d != ST_IDLE);
      busy_o  <= (state_d != ST_IDLE);
      done_o  <= done_d;

      if (accept_run_d) begin
        frames_q <= cfg_frames_i;
        gap_q    <= cfg_gap_i;
      end else begin
        frames_q <= frames_q;
        gap_q    <= gap_q;
      end

      // Counter holds remaining cycles minus one for ARM and GAP.
      if (accept_run_d) begin
        cnt_q <= GAP_WIDTH'(ARM_CYCLES - 1);
      end else if ((state_q == ST_SCAN) && (state_d == ST_GAP)) begin
        cnt_q <= gap_q - GAP_WIDTH'(1);
      end else if (((state_q == ST_ARM) || (state_q == ST_GAP)) &&
                   (cnt_q != GAP_WIDTH'(0))) begin
        cnt_q <= cnt_q - GAP_WIDTH'(1);
      end else begin
        cnt_q <= cnt_q;
      end

      // Watchdog restarts on every SCAN entry; SCAN exits before it can wrap.
      if ((state_q != ST_SCAN) && (state_d == ST_SCAN)) begin
        wd_q <= '0;
      end else if (state_q == ST_SCAN) begin
        wd_q <= wd_q + TIMEOUT_WIDTH'(1);
      end else begin
        wd_q <= wd_q;
      end

      if (accept_run_d || (state_d == ST_IDLE)) begin
        stop_pend_q <= 1'b0;
      end else if (stop_i && ((state_q == ST_START) || (state_q == ST_SCAN))) begin
        stop_pend_q <= 1'b1;
      end else begin
        stop_pend_q <= stop_pend_q;
      end

      if (accept_run_d) begin
        frame_cnt_o <= '0;
      end else if (frame_evt_d) begin
        frame_cnt_o <= cnt_next_d;
      end else begin
        frame_cnt_o <= frame_cnt_o;
      end

      if (accept_run_d) begin
        timeout_err_o <= 1'b0;
      end else if (wd_fire_d) begin
        timeout_err_o <= 1'b1;
      end else begin
        timeout_err_o <= timeout_err_o;
      end
    end
  end

endmodule : scan_sequencer

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
// Directed bench for scan_sequencer (TIMEOUT = 100). Inputs are driven and
// outputs sampled on the falling clock edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic        run_i;
  logic        stop_i;
  logic [15:0] cfg_frames_i;
  logic [7:0]  cfg_gap_i;
  logic        marker_a;
  logic        start_s;
  logic        speak_s;
  logic        busy_o;
  logic        done_o;
  logic        timeout_err_o;
  logic [15:0] frame_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  scan_sequencer #(
    .FRAME_CNT_WIDTH(16),
    .GAP_WIDTH      (8),
    .TIMEOUT        (100)
  ) dut (
    .clk_s        (clk_s),
    .rst_n_s      (rst_n_s),
    .run_i        (run_i),
    .stop_i       (stop_i),
    .cfg_frames_i (cfg_frames_i),
    .cfg_gap_i    (cfg_gap_i),
    .marker_a     (marker_a),
    .start_s      (start_s),
    .speak_s      (speak_s),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_err_o(timeout_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_s);
  endtask

  // run pulse sampled on one rising edge; returns on the falling edge after it
  task automatic do_run();
    run_i = 1'b1;
    step(1);
    run_i = 1'b0;
  endtask

  // one-cycle marker pulse; returns one falling edge after it was raised
  task automatic mark1();
    marker_a = 1'b1;
    step(1);
    marker_a = 1'b0;
  endtask

  initial begin
    rst_n_s      = 1'b0;
    run_i        = 1'b0;
    stop_i       = 1'b0;
    cfg_frames_i = 16'd0;
    cfg_gap_i    = 8'd0;
    marker_a     = 1'b0;

    // ---- reset state ----
    #1;
    chk("rst_start", {31'd0, start_s}, 32'd0);
    chk("rst_speak", {31'd0, speak_s}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o},  32'd0);
    chk("rst_done",  {31'd0, done_o},  32'd0);
    chk("rst_err",   {31'd0, timeout_err_o}, 32'd0);
    chk("rst_cnt",   {16'd0, frame_cnt_o}, 32'd0);
    step(2);
    rst_n_s = 1'b1;
    step(1);

    // ---- test 1: frames=2, gap=3 ----
    cfg_frames_i = 16'd2;
    cfg_gap_i    = 8'd3;
    do_run();
    chk("t1_busy",  {31'd0, busy_o},  32'd1);
    chk("t1_speak", {31'd0, speak_s}, 32'd1);
    chk("t1_arm1_start", {31'd0, start_s}, 32'd0);
    step(1);
    chk("t1_arm2_start", {31'd0, start_s}, 32'd0);
    step(1);
    chk("t1_start", {31'd0, start_s}, 32'd1);
    step(1);
    chk("t1_scan_start", {31'd0, start_s}, 32'd0);
    chk("t1_scan_speak", {31'd0, speak_s}, 32'd1);
    step(45);
    mark1();
    step(1);
    chk("t1_cnt_before_evt", {16'd0, frame_cnt_o}, 32'd0);
    step(1);
    chk("t1_cnt1", {16'd0, frame_cnt_o}, 32'd1);
    chk("t1_gap_start", {31'd0, start_s}, 32'd0);
    step(2);
    chk("t1_gap_end_start", {31'd0, start_s}, 32'd0);
    step(1);
    chk("t1_start2", {31'd0, start_s}, 32'd1);
    step(1);
    chk("t1_start2_end", {31'd0, start_s}, 32'd0);
    step(49);
    mark1();
    step(2);
    chk("t1_cnt2",  {16'd0, frame_cnt_o}, 32'd2);
    chk("t1_done",  {31'd0, done_o},  32'd1);
    chk("t1_speak_low", {31'd0, speak_s}, 32'd0);
    chk("t1_idle",  {31'd0, busy_o},  32'd0);
    step(1);
    chk("t1_done_pulse", {31'd0, done_o}, 32'd0);
    chk("t1_cnt_hold", {16'd0, frame_cnt_o}, 32'd2);

    // ---- test 2: continuous, gap=0, stop mid-SCAN ----
    cfg_frames_i = 16'd0;
    cfg_gap_i    = 8'd0;
    do_run();
    step(2);
    chk("t2_start", {31'd0, start_s}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(10);
      mark1();
      step(1);
      chk("t2_no_early_start", {31'd0, start_s}, 32'd0);
      step(1);
      chk("t2_restart", {31'd0, start_s}, 32'd1);
      chk("t2_cnt", {16'd0, frame_cnt_o}, i + 1);
    end
    step(1);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("t2_busy_pending", {31'd0, busy_o}, 32'd1);
    step(5);
    mark1();
    step(1);
    chk("t2_busy_until_evt", {31'd0, busy_o}, 32'd1);
    step(1);
    chk("t2_done", {31'd0, done_o}, 32'd1);
    chk("t2_cnt6", {16'd0, frame_cnt_o}, 32'd6);
    chk("t2_idle", {31'd0, busy_o}, 32'd0);
    chk("t2_no_start", {31'd0, start_s}, 32'd0);
    step(1);

    // ---- test 3: watchdog timeout ----
    cfg_frames_i = 16'd1;
    cfg_gap_i    = 8'd0;
    do_run();
    step(102);
    chk("t3_busy_99", {31'd0, busy_o}, 32'd1);
    chk("t3_err_99",  {31'd0, timeout_err_o}, 32'd0);
    step(1);
    chk("t3_err",  {31'd0, timeout_err_o}, 32'd1);
    chk("t3_idle", {31'd0, busy_o}, 32'd0);
    chk("t3_no_done", {31'd0, done_o}, 32'd0);
    step(1);
    chk("t3_no_done2", {31'd0, done_o}, 32'd0);
    chk("t3_sticky", {31'd0, timeout_err_o}, 32'd1);
    do_run();
    chk("t3_err_clr", {31'd0, timeout_err_o}, 32'd0);
    chk("t3_rerun_busy", {31'd0, busy_o}, 32'd1);
    // stop while in ARM
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("t3_arm_stop_done", {31'd0, done_o}, 32'd1);
    chk("t3_arm_stop_idle", {31'd0, busy_o}, 32'd0);
    chk("t3_arm_stop_speak", {31'd0, speak_s}, 32'd0);
    step(1);

    // ---- test 4: run+stop in IDLE, run while busy ----
    cfg_frames_i = 16'd0;
    cfg_gap_i    = 8'd2;
    run_i  = 1'b1;
    stop_i = 1'b1;
    step(1);
    run_i  = 1'b0;
    stop_i = 1'b0;
    chk("t4_runstop_busy", {31'd0, busy_o}, 32'd0);
    chk("t4_runstop_done", {31'd0, done_o}, 32'd0);
    step(1);
    chk("t4_runstop_busy2", {31'd0, busy_o}, 32'd0);
    do_run();
    step(2);
    chk("t4_start", {31'd0, start_s}, 32'd1);
    step(5);
    mark1();
    step(2);
    chk("t4_cnt1", {16'd0, frame_cnt_o}, 32'd1);
    chk("t4_gap", {31'd0, start_s}, 32'd0);
    run_i = 1'b1;
    cfg_frames_i = 16'd1;
    step(1);
    run_i = 1'b0;
    chk("t4_rerun_cnt",  {16'd0, frame_cnt_o}, 32'd1);
    chk("t4_rerun_busy", {31'd0, busy_o}, 32'd1);
    step(1);
    chk("t4_gap2_start", {31'd0, start_s}, 32'd1);

    // ---- test 5: held marker, stop in GAP ----
    step(3);
    marker_a = 1'b1;
    step(10);
    marker_a = 1'b0;
    chk("t5_held_cnt", {16'd0, frame_cnt_o}, 32'd2);
    chk("t5_held_busy", {31'd0, busy_o}, 32'd1);
    step(5);
    chk("t5_held_cnt2", {16'd0, frame_cnt_o}, 32'd2);
    mark1();
    step(2);
    chk("t5_cnt3", {16'd0, frame_cnt_o}, 32'd3);
    chk("t5_in_gap", {31'd0, start_s}, 32'd0);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    chk("t5_gap_stop_done", {31'd0, done_o}, 32'd1);
    chk("t5_gap_stop_idle", {31'd0, busy_o}, 32'd0);
    chk("t5_gap_stop_speak", {31'd0, speak_s}, 32'd0);
    step(6);
    chk("t5_no_start", {31'd0, start_s}, 32'd0);
    chk("t5_cnt_kept", {16'd0, frame_cnt_o}, 32'd3);

    // ---- test 6: async reset mid-SCAN ----
    cfg_frames_i = 16'd0;
    cfg_gap_i    = 8'd0;
    do_run();
    step(7);
    mark1();
    step(2);
    chk("t6_cnt1", {16'd0, frame_cnt_o}, 32'd1);
    chk("t6_start", {31'd0, start_s}, 32'd1);
    step(3);
    #2;
    rst_n_s = 1'b0;
    #1;
    chk("t6_rst_speak", {31'd0, speak_s}, 32'd0);
    chk("t6_rst_busy",  {31'd0, busy_o},  32'd0);
    chk("t6_rst_cnt",   {16'd0, frame_cnt_o}, 32'd0);
    chk("t6_rst_start", {31'd0, start_s}, 32'd0);
    step(1);
    rst_n_s = 1'b1;
    step(10);
    chk("t6_post_busy",  {31'd0, busy_o},  32'd0);
    chk("t6_post_start", {31'd0, start_s}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_scan_sequencer
